// File: rtl/onchip_memory_copier.sv
// Avalon-MM block FILL/COPY engine for a single-port on-chip RAM (s1), optional checksum via MEMORY_COPIER_CHECKSUM_EN.
// Latency: FILL N words -> done N+1 cycles after start; COPY N words -> done 3N+1 cycles; length 0 -> done after 1 cycle.
// Backpressure: none; the RAM slave has no waitrequest, start is ignored unless idle and not in the done cycle.
module onchip_memory_copier #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_W-1:0]     src,
  input  logic [ADDR_W-1:0]     dst,
  input  logic [ADDR_W:0]       length,
  input  logic [DATA_W-1:0]     fill_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic                  clken,
  input  logic [DATA_W-1:0]     readdata
);

  typedef enum logic [2:0] {IDLE, FILL_WR, CP_RD, CP_CAP, CP_WR, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_C = 1;

  state_t              state_q;
  logic [ADDR_W-1:0]   src_q, dst_q, addr_q;
  logic [ADDR_W:0]     cnt_q;
  logic [DATA_W-1:0]   fill_q, wdata_q;
  logic                busy_q, done_q, cs_q, wr_q;

  logic [ADDR_W-1:0]   src_d, dst_d;
  logic [ADDR_W:0]     cnt_d;
  logic                last_d, accept_d;

  // Pointer/count next values; pointers wrap modulo the address space.
  assign src_d    = src_q + ONE_A;
  assign dst_d    = dst_q + ONE_A;
  assign cnt_d    = cnt_q - ONE_C;
  assign last_d   = (cnt_q == ONE_C);
  // A start landing in the done cycle is dropped so the caller sees a clean handshake.
  assign accept_d = (state_q == IDLE) && start && !done_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign address    = addr_q;
  assign chipselect = cs_q;
  assign write      = wr_q;
  assign writedata  = wdata_q;
  assign byteenable = '1;
  assign clken      = 1'b1;

  // Command FSM. Bus outputs are registered, so each state's access appears
  // on the bus in the cycle after that state. The read issued from CP_RD is
  // therefore returned by the RAM at the CP_WR edge, where it is registered
  // straight into writedata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          cs_q   <= 1'b0;
          wr_q   <= 1'b0;
          if (accept_d) begin
            src_q  <= src;
            dst_q  <= dst;
            cnt_q  <= length;
            fill_q <= fill_data;
            busy_q <= 1'b1;
            if (length == '0)  state_q <= DONE;
            else if (op)       state_q <= CP_RD;
            else               state_q <= FILL_WR;
          end
        end
        FILL_WR: begin
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= dst_q;
          wdata_q <= fill_q;
          dst_q   <= dst_d;
          cnt_q   <= cnt_d;
          if (last_d) state_q <= DONE;
        end
        CP_RD: begin
          cs_q    <= 1'b1;
          wr_q    <= 1'b0;
          addr_q  <= src_q;
          state_q <= CP_CAP;
        end
        CP_CAP: begin
          cs_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= CP_WR;
        end
        CP_WR: begin
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= dst_q;
          wdata_q <= readdata;
          src_q   <= src_d;
          dst_q   <= dst_d;
          cnt_q   <= cnt_d;
          state_q <= last_d ? DONE : CP_RD;
        end
        DONE: begin
          cs_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEMORY_COPIER_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  // Wrapping sum of every word written; cleared when a command is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cksum_q <= '0;
    else if (accept_d)            cksum_q <= '0;
    else if (state_q == FILL_WR)  cksum_q <= cksum_q + fill_q;
    else if (state_q == CP_WR)    cksum_q <= cksum_q + readdata;
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/onchip_memory_copier.md
# onchip_memory_copier

Avalon-MM master that drives the s1 port of a single-port on-chip RAM: 32-bit data, 8-bit word address, one-cycle read latency. It executes FILL (write a constant to a word range) and COPY (read a source range, write it to a destination range) commands issued by a simple start/done control interface. It sits beside the Nios II data master on the same RAM slave, so the processor can offload block initialisation and buffer moves.

## Interface
Parameters:
- ADDR_W, 8: word-address width; the address space is 2^ADDR_W words.
- DATA_W, 32: data width; byteenable width is DATA_W/8.

Ports (all synchronous to clk except reset_n):
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command strobe; ignored while busy=1
- op  in  1  0 = FILL, 1 = COPY; sampled on start
- src  in  ADDR_W  COPY source start word; sampled on start
- dst  in  ADDR_W  destination start word; sampled on start
- length  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled on start
- fill_data  in  DATA_W  FILL pattern; sampled on start
- busy  out  1  high from the cycle after an accepted start until done pulses
- done  out  1  one-cycle completion pulse
- checksum  out  DATA_W  see Configuration
- address  out  ADDR_W  master address to RAM
- byteenable  out  DATA_W/8  always all-ones
- chipselect  out  1  bus access this cycle
- write  out  1  write access (valid only with chipselect)
- writedata  out  DATA_W  write data
- clken  out  1  RAM clock enable; constant 1 out of reset
- readdata  in  DATA_W  RAM read data; valid in the cycle after a read address is presented

## Operation
- Reset values: busy=0, done=0, checksum=0, address=0, chipselect=0, write=0, writedata=0, byteenable=all-ones, clken=1; FSM in IDLE.
- States: IDLE, FILL_WR, CP_RD, CP_CAP, CP_WR, DONE.
- IDLE: on start with length=0 -> DONE with no bus access. FILL -> FILL_WR. COPY -> CP_RD. Latch src, dst, length, fill_data and op.
- FILL_WR: chipselect=1, write=1, address=dst pointer, writedata=fill_data; one word per cycle. Advance pointer, decrement count; when count reaches 0 -> DONE.
- CP_RD: chipselect=1, write=0, address=src pointer -> CP_CAP.
- CP_CAP: chipselect=0; register readdata -> CP_WR.
- CP_WR: chipselect=1, write=1, address=dst pointer, writedata=captured word. Advance both pointers, decrement count; if count>0 -> CP_RD, else DONE.
- DONE: done=1 for one cycle, busy=0 next; -> IDLE.
- Pointers increment modulo 2^ADDR_W; ranges wrap from the top word to word 0.
- Overlap: COPY always runs ascending, one word at a time. With dst>src and overlapping ranges, already-written words are re-read; this forward propagation is specified behaviour, not a defect.
- Asynchronous reset mid-command aborts immediately: chipselect/write drop with reset, no done pulse.

## Timing
- FILL of N words: the start cycle, then N FILL_WR cycles, then a 1-cycle DONE. done rises N+1 cycles after the start edge.
- COPY of N words: 3N bus-state cycles + DONE. done rises 3N+1 cycles after the start edge.
- length=0: done rises 1 cycle after the start edge; busy pulses for that cycle only.
- start coincident with done: ignored. A new start is accepted in IDLE only, at the earliest the cycle after done.
- The bus never stalls: the RAM slave has no waitrequest.

## Configuration
- MEMORY_COPIER_CHECKSUM_EN defined: checksum is cleared on an accepted start and accumulates a DATA_W-bit wrapping sum of every word written (FILL: fill_data × N; COPY: each captured word). It is stable from the done cycle until the next accepted start.
- Undefined: checksum is tied to 0 and no adder is synthesised.

## Test plan
- FILL dst=0x10, length=4, fill_data=0xDEADBEEF -> words 0x10..0x13 = 0xDEADBEEF, 0x14 untouched; done 5 cycles after start; checksum=0x7AB6FBBC when the macro is enabled.
- COPY src=0x00, dst=0x80, length=3, RAM[0..2]=1,2,3 -> RAM[0x80..0x82]=1,2,3; done 10 cycles after start; read address held exactly one cycle per word.
- FILL dst=0xFE, length=4 -> words 0xFE, 0xFF, 0x00, 0x01 written, in that order.
- length=0 -> done the next cycle, chipselect never asserted; start pulsed while busy during a COPY of 8 words -> ignored, first command completes unchanged.
- COPY src=0x20, dst=0x21, length=4, RAM[0x20]=0xA5 -> RAM[0x21..0x24] all 0xA5.
- reset_n asserted low mid-COPY -> chipselect=0, write=0, busy=0 asynchronously; no done pulse; after release, a new FILL runs correctly.
